spu_issue_scoreboard: RTL

- Single-issue scheduler between the instruction decoder and the 128 x 128-bit register file.
- Tracks every in-flight write to RT and stalls issue on RAW/WAW hazards and on write-port collisions; the register file has one write port.
- Owns the write-back schedule: its wb_valid/wb_rt outputs drive the register file's regWriteEnable and write address.

---
 rtl/spu_sched_pkg.sv | 21 ++
 rtl/spu_wb_slot_shifter.sv | 29 ++
 rtl/spu_issue_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/spu_sched_pkg.sv
// spu_sched_pkg: shared constants and the write-back slot type
// for the SPU issue scoreboard and its slot shifter.
package spu_sched_pkg;

  localparam int NUM_REGS   = 128;
  localparam int REG_IDX_W  = 7;
  localparam int MAX_LAT    = 8;
  localparam int LAT_W      = 4;
  localparam int SLOT_IDX_W = $clog2(MAX_LAT);

  // issue_src_used bit positions
  localparam int SRC_RA = 0;
  localparam int SRC_RB = 1;
  localparam int SRC_RC = 2;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rt;
  } wb_slot_t;

endpackage

// File: rtl/spu_wb_slot_shifter.sv
// spu_wb_slot_shifter: write-back slot array; slot[0] is this cycle's write.
// Ports: clk, reset, flush, loadEn/loadIdx/loadRt (post-shift load), slots (all).
module spu_wb_slot_shifter
  import spu_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  loadEn,
  input  logic [SLOT_IDX_W-1:0] loadIdx,
  input  logic [REG_IDX_W-1:0]  loadRt,
  output wb_slot_t              slots [MAX_LAT]
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < MAX_LAT; i++)
        slots[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT - 1; i++)
        slots[i] <= slots[i+1];
      slots[MAX_LAT-1] <= '0;
      // load wins over the shift; port hazard keeps the target empty
      if (loadEn)
        slots[loadIdx] <= '{valid: 1'b1, rt: loadRt};
    end
  end

endmodule

// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard: single-issue RAW/WAW/write-port hazard scheduler.
// Ports: issue_* (decoder in), issue_ready, stall_raw/stall_wb/lat_err,
// flush, wb_valid/wb_rt (regfile write), pending_cnt.
// Option: define SPU_SCOREBOARD_BYPASS_EN to forward from slot[0].
module spu_issue_scoreboard
  import spu_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] issue_rt,
  input  logic                 issue_rt_we,
  input  logic [REG_IDX_W-1:0] issue_ra,
  input  logic [REG_IDX_W-1:0] issue_rb,
  input  logic [REG_IDX_W-1:0] issue_rc,
  input  logic [2:0]           issue_src_used,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 flush,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rt,
  output logic                 stall_raw,
  output logic                 stall_wb,
  output logic                 lat_err,
  output logic [LAT_W-1:0]     pending_cnt
);

`ifdef SPU_SCOREBOARD_BYPASS_EN
  // slot[0] value is forwarded, so it cannot cause a RAW stall
  localparam int RAW_FIRST = 1;
`else
  localparam int RAW_FIRST = 0;
`endif

  wb_slot_t             slots [MAX_LAT];
  logic [REG_IDX_W-1:0] srcs  [3];
  logic                 rawHit;
  logic                 wawHit;
  logic                 portHit;
  logic                 latBad;
  logic                 accept;
  logic                 loadEn;
  logic [SLOT_IDX_W-1:0] loadIdx;

  assign srcs[SRC_RA] = issue_ra;
  assign srcs[SRC_RB] = issue_rb;
  assign srcs[SRC_RC] = issue_rc;

  always_comb begin
    rawHit = 1'b0;
    for (int i = RAW_FIRST; i < MAX_LAT; i++)
      for (int j = 0; j < 3; j++)
        if (slots[i].valid && issue_src_used[j] &&
            srcs[j] == slots[i].rt)
          rawHit = 1'b1;
  end

  always_comb begin
    wawHit = 1'b0;
    for (int i = 0; i < MAX_LAT; i++)
      if (issue_rt_we && slots[i].valid &&
          issue_rt == slots[i].rt)
        wawHit = 1'b1;
  end

  // pre-shift slot[lat] becomes the post-shift target slot[lat-1]
  always_comb begin
    portHit = 1'b0;
    if (issue_rt_we && issue_lat < LAT_W'(MAX_LAT))
      portHit = slots[SLOT_IDX_W'(issue_lat)].valid;
  end

  assign latBad = (issue_lat == '0) ||
                  (issue_lat > LAT_W'(MAX_LAT));

  assign lat_err     = issue_valid & latBad;
  assign stall_raw   = issue_valid & rawHit;
  assign stall_wb    = issue_valid & (wawHit | portHit);
  assign issue_ready = ~stall_raw & ~stall_wb &
                       ~lat_err & ~flush;

  assign accept  = issue_valid & issue_ready & ~flush;
  assign loadEn  = accept & issue_rt_we;
  assign loadIdx = SLOT_IDX_W'(issue_lat - 1'b1);

  spu_wb_slot_shifter uShifter (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .loadEn  (loadEn),
    .loadIdx (loadIdx),
    .loadRt  (issue_rt),
    .slots   (slots)
  );

  assign wb_valid = slots[0].valid;
  assign wb_rt    = slots[0].rt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pending_cnt <= '0;
    end else begin
      case ({loadEn, wb_valid})
        2'b10:   pending_cnt <= pending_cnt + 1'b1;
        2'b01:   pending_cnt <= pending_cnt - 1'b1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

endmodule
